// File: rtl/oled_ring_ctrl.sv
// Parametrised OLED ring renderer: debounced buttons drive ring size/position/colour, registered RGB565 out.
// Optional RING_COLOR_CYCLE_EN: C on an active ring cycles GREEN -> BLUE -> YELLOW.

module oled_ring_debounce #(
    parameter int DEB_CYCLES = 1250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic {READY, LOCK} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic done;

    assign done = (cnt == CW'(DEB_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= READY;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (state == READY) cnt <= '0;
        else if (!done)          cnt <= cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            READY: if (btn) state_nxt = LOCK;
            LOCK:  if (done && !btn) state_nxt = READY;
            default: state_nxt = READY;
        endcase
    end

    always_comb begin
        pulse = (state == READY) && btn;
    end
endmodule

module oled_ring_ctrl #(
    parameter int DISP_W       = 96,
    parameter int DISP_H       = 64,
    parameter int BORDER_DIST  = 4,
    parameter int BORDER_THICK = 3,
    parameter int INIT_DIA     = 30,
    parameter int MIN_DIA      = 10,
    parameter int MAX_DIA      = 50,
    parameter int DIA_STEP     = 5,
    parameter int RING_THICK   = 5,
    parameter int MOVE_STEP    = 4,
    parameter int DEB_CYCLES   = 1250000
) (
    input  logic                      clk_mhz_6_25,
    input  logic                      reset_n,
    input  logic                      btnU,
    input  logic                      btnD,
    input  logic                      btnL,
    input  logic                      btnR,
    input  logic                      btnC,
    input  logic [$clog2(DISP_W)-1:0] x,
    input  logic [$clog2(DISP_H)-1:0] y,
    output logic [15:0]               oled_data,
    output logic                      ring_active,
    output logic [7:0]                outer_dia
);
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] BLUE   = 16'h001F;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] RED    = 16'hF800;
    localparam int EDGE = BORDER_DIST + BORDER_THICK;

    logic [4:0]  btn_raw, pulse;
    logic [7:0]  cx, cx_nxt, dia_nxt;
    logic [15:0] colour, colour_nxt, pix_nxt;
    logic        active_nxt, c_hit;
    int          grow, shrink, lo, hi, lo_g, hi_g, mv;
    logic [31:0] dx, dy, d4, rin, rout;
    logic        excl, border;

    assign btn_raw = {btnC, btnU, btnD, btnL, btnR};

    for (genvar i = 0; i < 5; i++) begin : g_deb
        oled_ring_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk_mhz_6_25),
            .rst_n (reset_n),
            .btn   (btn_raw[i]),
            .pulse (pulse[i])
        );
    end

`ifdef RING_COLOR_CYCLE_EN
    assign c_hit = pulse[4];
`else
    // C on an active ring is a no-op here, so it must not block U/D/L/R.
    assign c_hit = pulse[4] && !ring_active;
`endif

    always_comb begin
        active_nxt = ring_active;
        dia_nxt    = outer_dia;
        cx_nxt     = cx;
        colour_nxt = colour;
        grow       = int'(outer_dia) + DIA_STEP;
        shrink     = int'(outer_dia) - DIA_STEP;
        lo         = EDGE + int'(outer_dia) / 2;
        hi         = DISP_W - 1 - EDGE - int'(outer_dia) / 2;
        lo_g       = EDGE + grow / 2;
        hi_g       = DISP_W - 1 - EDGE - grow / 2;
        mv         = 0;
        if (c_hit) begin
            if (!ring_active) active_nxt = 1'b1;
`ifdef RING_COLOR_CYCLE_EN
            else colour_nxt = (colour == GREEN) ? BLUE : (colour == BLUE) ? YELLOW : GREEN;
`endif
        end else if (ring_active) begin
            if (pulse[3]) begin
                if (grow <= MAX_DIA) begin
                    dia_nxt = 8'(grow);
                    // Re-clamp with the new radius so the ring stays off the border.
                    if (int'(cx) > hi_g)      cx_nxt = 8'(hi_g);
                    else if (int'(cx) < lo_g) cx_nxt = 8'(lo_g);
                end
            end else if (pulse[2]) begin
                if (shrink >= MIN_DIA) dia_nxt = 8'(shrink);
            end else if (pulse[1]) begin
                mv     = int'(cx) - MOVE_STEP;
                cx_nxt = (mv < lo) ? 8'(lo) : 8'(mv);
            end else if (pulse[0]) begin
                mv     = int'(cx) + MOVE_STEP;
                cx_nxt = (mv > hi) ? 8'(hi) : 8'(mv);
            end
        end
    end

    always_ff @(posedge clk_mhz_6_25 or negedge reset_n) begin
        if (!reset_n) begin
            ring_active <= 1'b0;
            outer_dia   <= 8'(INIT_DIA);
            cx          <= 8'(DISP_W / 2);
            colour      <= GREEN;
        end else begin
            ring_active <= active_nxt;
            outer_dia   <= dia_nxt;
            cx          <= cx_nxt;
            colour      <= colour_nxt;
        end
    end

    always_comb begin
        dx   = (32'(x) >= 32'(cx)) ? 32'(x) - 32'(cx) : 32'(cx) - 32'(x);
        dy   = (32'(y) >= 32'(DISP_H / 2)) ? 32'(y) - 32'(DISP_H / 2) : 32'(DISP_H / 2) - 32'(y);
        d4   = 32'd4 * (dx * dx + dy * dy);
        rout = 32'(outer_dia) * 32'(outer_dia);
        rin  = (32'(outer_dia) - 32'(RING_THICK)) * (32'(outer_dia) - 32'(RING_THICK));
        excl = (int'(x) < BORDER_DIST) || (int'(x) >= DISP_W - BORDER_DIST) ||
               (int'(y) < BORDER_DIST) || (int'(y) >= DISP_H - BORDER_DIST);
        border = (int'(x) < EDGE) || (int'(x) >= DISP_W - EDGE) ||
                 (int'(y) < EDGE) || (int'(y) >= DISP_H - EDGE);
        if (excl)                                      pix_nxt = 16'h0000;
        else if (border)                               pix_nxt = RED;
        else if (ring_active && d4 >= rin && d4 <= rout) pix_nxt = colour;
        else                                           pix_nxt = 16'h0000;
    end

    always_ff @(posedge clk_mhz_6_25 or negedge reset_n) begin
        if (!reset_n) oled_data <= 16'h0000;
        else          oled_data <= pix_nxt;
    end
endmodule

// File: tb/tb_oled_ring_ctrl.sv
// Directed bench for oled_ring_ctrl with a short debounce window.

module tb_oled_ring_ctrl;
    localparam int DEB = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] btns = 5'b0;   // {C,U,D,L,R}
    logic [6:0] x = '0;
    logic [5:0] y = '0;
    logic [15:0] oled_data;
    logic       ring_active;
    logic [7:0] outer_dia;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          px;
        int          py;
        logic [15:0] exp;
    } pix_t;

    oled_ring_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk_mhz_6_25 (clk),
        .reset_n      (reset_n),
        .btnU         (btns[3]),
        .btnD         (btns[2]),
        .btnL         (btns[1]),
        .btnR         (btns[0]),
        .btnC         (btns[4]),
        .x            (x),
        .y            (y),
        .oled_data    (oled_data),
        .ring_active  (ring_active),
        .outer_dia    (outer_dia)
    );

    always #80 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic pix(input string nm, input int px, input int py, input logic [15:0] exp);
        @(negedge clk);
        x = 7'(px);
        y = 6'(py);
        @(posedge clk);
        #1;
        chk($sformatf("%s(%0d,%0d)", nm, px, py), 32'(oled_data), 32'(exp));
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge clk);
        btns = m;
        @(negedge clk);
        btns = 5'b0;
        repeat (DEB + 4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #20;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    pix_t idle_vec[4];
    pix_t act_vec[10];
    int   dseq[5];

    initial begin
        idle_vec[0] = '{48, 32, 16'h0000};
        idle_vec[1] = '{62, 32, 16'h0000};
        idle_vec[2] = '{5,  20, 16'hF800};
        idle_vec[3] = '{2,  2,  16'h0000};

        act_vec[0] = '{62, 32, 16'h07E0};
        act_vec[1] = '{5,  20, 16'hF800};
        act_vec[2] = '{2,  2,  16'h0000};
        act_vec[3] = '{48, 32, 16'h0000};
        act_vec[4] = '{60, 32, 16'h0000};
        act_vec[5] = '{63, 32, 16'h07E0};
        act_vec[6] = '{64, 32, 16'h0000};
        act_vec[7] = '{48, 19, 16'h07E0};
        act_vec[8] = '{90, 30, 16'hF800};
        act_vec[9] = '{93, 60, 16'h0000};

        dseq = '{25, 20, 15, 10, 10};

        // T1: reset state
        do_reset();
        #1;
        chk("rst_active", 32'(ring_active), 32'd0);
        chk("rst_dia", 32'(outer_dia), 32'd30);
        for (int i = 0; i < 4; i++) pix("idle", idle_vec[i].px, idle_vec[i].py, idle_vec[i].exp);

        // T4b / T2: C+U together on inactive ring only activates
        press(5'b11000);
        #1;
        chk("cu_active", 32'(ring_active), 32'd1);
        chk("cu_dia", 32'(outer_dia), 32'd30);
        for (int i = 0; i < 10; i++) pix("act", act_vec[i].px, act_vec[i].py, act_vec[i].exp);

        // C on an active ring together with U
        press(5'b11000);
        #1;
`ifdef RING_COLOR_CYCLE_EN
        chk("c_active_dia", 32'(outer_dia), 32'd30);
        pix("blue", 62, 32, 16'h001F);
`else
        chk("c_active_dia", 32'(outer_dia), 32'd35);
`endif

        // T3: held U gives one step, then clamp at MAX
        do_reset();
        press(5'b10000);
        @(negedge clk);
        btns = 5'b01000;
        repeat (3 * DEB) @(posedge clk);
        @(negedge clk);
        btns = 5'b0;
        repeat (DEB + 4) @(posedge clk);
        #1;
        chk("hold_u_dia", 32'(outer_dia), 32'd35);
        for (int i = 0; i < 4; i++) begin
            press(5'b01000);
            #1;
            chk($sformatf("grow%0d", i), 32'(outer_dia), 32'((i < 3) ? 40 + 5 * i : 50));
        end

        // T4: shrink clamps at MIN
        do_reset();
        press(5'b10000);
        for (int i = 0; i < 5; i++) begin
            press(5'b00100);
            #1;
            chk($sformatf("shrink%0d", i), 32'(outer_dia), 32'(dseq[i]));
        end

        // U on inactive ring is ignored
        do_reset();
        press(5'b01000);
        #1;
        chk("u_idle_dia", 32'(outer_dia), 32'd30);

        // T5: cx saturates at 73, growing re-clamps to 71
        press(5'b10000);
        for (int i = 0; i < 20; i++) press(5'b00001);
        pix("cx73_in", 58, 32, 16'h07E0);
        pix("cx73_out", 54, 32, 16'h0000);
        press(5'b01000);
        #1;
        chk("t5_dia", 32'(outer_dia), 32'd35);
        pix("cx71_left", 54, 32, 16'h07E0);
        pix("cx71_right", 88, 32, 16'h07E0);

        // L back off the right edge
        press(5'b00010);
        pix("cx67", 50, 32, 16'h07E0);

        // T6: reset mid-LOCK while active
        do_reset();
        press(5'b10000);
        pix("pre_rst", 62, 32, 16'h07E0);
        @(negedge clk);
        btns = 5'b01000;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_dia", 32'(outer_dia), 32'd35);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_oled", 32'(oled_data), 32'd0);
        chk("mid_rst_active", 32'(ring_active), 32'd0);
        chk("mid_rst_dia", 32'(outer_dia), 32'd30);
        @(negedge clk);
        reset_n = 1'b1;
        btns = 5'b10000;
        @(posedge clk);
        #1;
        chk("post_rst_c", 32'(ring_active), 32'd1);
        @(negedge clk);
        btns = 5'b01000;
        @(posedge clk);
        #1;
        chk("post_rst_u", 32'(outer_dia), 32'd35);
        @(negedge clk);
        btns = 5'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
